// File: rtl/controlador_ventana_filas.sv
// controlador_ventana_filas
// Read-address sequencer for a vertical sliding window over image rows.
// For each window position it walks the word columns and, per column, issues
// one read per window row (row index varies fastest) through a valid/accept
// handshake. Between window positions one idle cycle slides the row base.
module controlador_ventana_filas #(
    parameter int BITS_DIRECCION    = 11,
    parameter int PALABRAS_POR_FILA = 16,
    parameter int FILAS_IMAGEN      = 128,
    parameter int FILAS_VENTANA     = 3,
    localparam int BITS_K = (FILAS_VENTANA > 1) ? $clog2(FILAS_VENTANA) : 1,
    localparam int BITS_P = (PALABRAS_POR_FILA > 1) ? $clog2(PALABRAS_POR_FILA) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iniciar,
    input  logic                      detener,
    input  logic                      mem_aceptado,
    output logic                      mem_solicitud,
    output logic [BITS_DIRECCION-1:0] mem_direccion,
    output logic [BITS_K-1:0]         fila_ventana,
    output logic [BITS_P-1:0]         palabra,
    output logic                      ocupado,
    output logic                      fin
);

    // Window-position counter wide enough to hold FILAS_IMAGEN-FILAS_VENTANA.
    localparam int BITS_W = (FILAS_IMAGEN > 1) ? $clog2(FILAS_IMAGEN) : 1;

    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] LEER    = 2'd1;
    localparam logic [1:0] AVANZAR = 2'd2;
    localparam logic [1:0] FIN     = 2'd3;

    localparam logic [BITS_K-1:0]         K_ULT = BITS_K'(FILAS_VENTANA - 1);
    localparam logic [BITS_P-1:0]         P_ULT = BITS_P'(PALABRAS_POR_FILA - 1);
    localparam logic [BITS_W-1:0]         W_ULT = BITS_W'(FILAS_IMAGEN - FILAS_VENTANA);
    localparam logic [BITS_DIRECCION-1:0] PASO  = BITS_DIRECCION'(PALABRAS_POR_FILA);

    logic [1:0]                estado;
    logic [BITS_DIRECCION-1:0] base;     // first word of the top window row
    logic [BITS_DIRECCION-1:0] despl;    // k * PALABRAS_POR_FILA, kept incrementally
    logic [BITS_P-1:0]         p;        // word column
    logic [BITS_K-1:0]         k;        // row inside the window
    logic [BITS_W-1:0]         ventana;  // window position = base / PALABRAS_POR_FILA

    logic abortar;
    logic transfer;
    logic ult_fila;
    logic ult_palabra;
    logic ult_ventana;

    assign abortar     = detener && (estado != REPOSO);
    assign transfer    = (estado == LEER) && mem_aceptado;
    assign ult_fila    = (k == K_ULT);
    assign ult_palabra = (p == P_ULT);
    assign ult_ventana = (ventana == W_ULT);

    // State sequencing; an abort always wins and lands in REPOSO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= REPOSO;
        end else if (abortar) begin
            estado <= REPOSO;
        end else begin
            case (estado)
                REPOSO:  if (iniciar) estado <= LEER;
                LEER:    if (transfer && ult_fila && ult_palabra) estado <= AVANZAR;
                AVANZAR: estado <= ult_ventana ? FIN : LEER;
                FIN:     estado <= REPOSO;
                default: estado <= REPOSO;
            endcase
        end
    end

    // Counters: k steps first, then p; the base slides one row per window.
    // The row offset is accumulated instead of multiplied so the address
    // path is just a three-input add.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base    <= '0;
            despl   <= '0;
            p       <= '0;
            k       <= '0;
            ventana <= '0;
        end else if (abortar || estado == FIN || (estado == REPOSO && iniciar)) begin
            base    <= '0;
            despl   <= '0;
            p       <= '0;
            k       <= '0;
            ventana <= '0;
        end else if (transfer) begin
            if (ult_fila) begin
                k     <= '0;
                despl <= '0;
                // On the last column p is left alone; AVANZAR rewinds it.
                if (!ult_palabra) p <= p + 1'b1;
            end else begin
                k     <= k + 1'b1;
                despl <= despl + PASO;
            end
        end else if (estado == AVANZAR && !ult_ventana) begin
            base    <= base + PASO;
            ventana <= ventana + 1'b1;
            p       <= '0;
            k       <= '0;
            despl   <= '0;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears
    // them immediately; request fields read as zero outside LEER.
    always_comb begin
        mem_solicitud = (estado == LEER);
        mem_direccion = '0;
        fila_ventana  = '0;
        palabra       = '0;
        if (estado == LEER) begin
            mem_direccion = base + despl + BITS_DIRECCION'(p);
            fila_ventana  = k;
            palabra       = p;
        end
        ocupado = (estado != REPOSO);
        fin     = (estado == FIN);
    end

endmodule

// File: tb/tb_controlador_ventana_filas.sv
// Directed bench: default-sized DUT (full runs with steady, stalled and
// random acceptance, ignored iniciar, detener, async reset) and a small
// 4-row / 4-window / 2-word DUT with a hand-written address list.
module tb_controlador_ventana_filas;

    logic clk;
    logic reset;

    logic        iniciar_a, detener_a, acep_a;
    logic        sol_a, ocupado_a, fin_a;
    logic [10:0] dir_a;
    logic [1:0]  fila_a;
    logic [3:0]  pal_a;

    logic        iniciar_b, detener_b, acep_b;
    logic        sol_b, ocupado_b, fin_b;
    logic [10:0] dir_b;
    logic [1:0]  fila_b;
    logic [0:0]  pal_b;

    int errores = 0;
    int total   = 0;

    int  cyc     = 0;
    int  n_a     = 0;
    int  n_fin   = 0;
    int  ult_tx  = 0;
    int  fin_cyc = 0;
    bit  mon_a   = 0;

    controlador_ventana_filas dut_a (
        .clk(clk), .reset(reset), .iniciar(iniciar_a), .detener(detener_a),
        .mem_aceptado(acep_a), .mem_solicitud(sol_a), .mem_direccion(dir_a),
        .fila_ventana(fila_a), .palabra(pal_a), .ocupado(ocupado_a), .fin(fin_a)
    );

    controlador_ventana_filas #(
        .BITS_DIRECCION(11), .PALABRAS_POR_FILA(2), .FILAS_IMAGEN(4), .FILAS_VENTANA(4)
    ) dut_b (
        .clk(clk), .reset(reset), .iniciar(iniciar_b), .detener(detener_b),
        .mem_aceptado(acep_b), .mem_solicitud(sol_b), .mem_direccion(dir_b),
        .fila_ventana(fila_b), .palabra(pal_b), .ocupado(ocupado_b), .fin(fin_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int esp);
        total++;
        if (obs !== esp) begin
            errores++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Reference for transfer n of a default-sized run: 48 transfers per window,
    // window row fastest, then word column.
    function automatic int esp_dir(input int n);
        int w, r;
        w = n / 48;
        r = n % 48;
        return ((w + r % 3) * 16 + r / 3) % 2048;
    endfunction

    // Scoreboard: every accepted request of dut_a is checked against the model.
    always @(negedge clk) begin
        cyc++;
        if (mon_a) begin
            if (sol_a && acep_a) begin
                chk("dir_tx",   int'(dir_a),  esp_dir(n_a));
                chk("fila_tx",  int'(fila_a), (n_a % 48) % 3);
                chk("pal_tx",   int'(pal_a),  (n_a % 48) / 3);
                n_a++;
                ult_tx = cyc;
            end
            if (fin_a) begin
                n_fin++;
                fin_cyc = cyc;
            end
        end
    end

    // modo 0: always accept, 1: one 5-cycle stall at address 17, 2: random
    task automatic run_a(input int modo);
        bit hecho, parado;
        hecho  = 0;
        parado = 0;
        n_a    = 0;
        n_fin  = 0;
        mon_a  = 1;
        acep_a = 1'b1;
        iniciar_a = 1'b1;
        step;
        iniciar_a = 1'b0;
        chk("ocupado_ini", int'(ocupado_a), 1);
        chk("dir_ini", int'(dir_a), 0);
        for (int c = 0; c < 30000 && !hecho; c++) begin
            acep_a = (modo == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (modo == 1 && !parado && sol_a && int'(dir_a) == 17) begin
                parado = 1;
                acep_a = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step;
                    chk("stall_dir",  int'(dir_a),  17);
                    chk("stall_fila", int'(fila_a), 1);
                    chk("stall_pal",  int'(pal_a),  1);
                end
                acep_a = 1'b1;
            end
            step;
            if (fin_a) hecho = 1;
        end
        chk("fin_visto", int'(hecho), 1);
        if (modo == 1) chk("stall_hecho", int'(parado), 1);
        step;
        chk("total_tx", n_a, 6048);
        chk("fin_lat", fin_cyc - ult_tx, 2);
        chk("fin_pulso", int'(fin_a), 0);
        chk("ocupado_fin", int'(ocupado_a), 0);
        step;
        chk("n_fin", n_fin, 1);
        mon_a = 0;
    endtask

    initial begin
        int tabla_b[8] = '{0, 2, 4, 6, 1, 3, 5, 7};

        reset = 1'b0;
        iniciar_a = 1'b0; detener_a = 1'b0; acep_a = 1'b0;
        iniciar_b = 1'b0; detener_b = 1'b0; acep_b = 1'b0;
        #12;
        chk("rst_sol",  int'(sol_a),     0);
        chk("rst_dir",  int'(dir_a),     0);
        chk("rst_ocup", int'(ocupado_a), 0);
        chk("rst_fin",  int'(fin_a),     0);
        reset = 1'b1;
        step;
        step;
        chk("idle_sol", int'(sol_a), 0);

        run_a(0);
        run_a(1);
        run_a(2);

        // iniciar mid-run is ignored; detener aborts without fin
        n_a = 0; n_fin = 0; mon_a = 1; acep_a = 1'b1;
        iniciar_a = 1'b1;
        step;
        iniciar_a = 1'b0;
        for (int c = 0; c < 1000 && n_a < 200; c++) begin
            iniciar_a = (n_a == 100);
            step;
        end
        iniciar_a = 1'b0;
        chk("pre_det_n", n_a, 200);
        detener_a = 1'b1;
        step;
        detener_a = 1'b0;
        chk("det_sol",  int'(sol_a),     0);
        chk("det_ocup", int'(ocupado_a), 0);
        chk("det_n",    n_a,             201);
        repeat (5) step;
        chk("det_sol2", int'(sol_a), 0);
        chk("det_fin",  n_fin,       0);
        n_a = 0;
        iniciar_a = 1'b1;
        step;
        iniciar_a = 1'b0;
        chk("restart_dir", int'(dir_a), 0);
        chk("restart_sol", int'(sol_a), 1);
        for (int c = 0; c < 100 && n_a < 10; c++) step;
        detener_a = 1'b1;
        step;
        detener_a = 1'b0;
        mon_a = 0;

        // asynchronous reset between clock edges in the middle of LEER
        iniciar_a = 1'b1;
        step;
        iniciar_a = 1'b0;
        repeat (20) step;
        chk("pre_rst_sol", int'(sol_a), 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_sol",  int'(sol_a),     0);
        chk("arst_dir",  int'(dir_a),     0);
        chk("arst_fila", int'(fila_a),    0);
        chk("arst_pal",  int'(pal_a),     0);
        chk("arst_ocup", int'(ocupado_a), 0);
        chk("arst_fin",  int'(fin_a),     0);
        reset = 1'b1;
        repeat (3) step;
        chk("post_rst_sol",  int'(sol_a),     0);
        chk("post_rst_ocup", int'(ocupado_a), 0);

        // small geometry: one window covering the whole image
        acep_b = 1'b1;
        iniciar_b = 1'b1;
        step;
        iniciar_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b_sol", int'(sol_b), 1);
            chk("b_dir", int'(dir_b), tabla_b[i]);
            step;
        end
        chk("b_avz_sol",  int'(sol_b),     0);
        chk("b_avz_fin",  int'(fin_b),     0);
        chk("b_avz_ocup", int'(ocupado_b), 1);
        step;
        chk("b_fin",      int'(fin_b),     1);
        chk("b_fin_sol",  int'(sol_b),     0);
        step;
        chk("b_fin_off",  int'(fin_b),     0);
        chk("b_ocup_off", int'(ocupado_b), 0);

        $display("Result: errors=%0d of %0d checks", errores, total);
        $finish;
    end

endmodule
